// File: rtl/rr_mux_scheduler.sv
// rtl/rr_mux_scheduler.sv - round-robin owner of a shared 4:1 mux, bursts bounded to MAX_BURST beats
module rr_mux_scheduler #(
  parameter int DW        = 2,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  input  logic          out_ready,
  output logic [1:0]    sel,
  output logic [3:0]    gnt,
  output logic          out_valid,
  output logic [DW-1:0] y,
  output logic          busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  logic [0:0]    state;
  logic [1:0]    ptr;
  logic [3:0]    beat_cnt;
  logic [1:0]    winner;
  logic [1:0]    idx;
  logic [DW-1:0] mux_data;
  logic          burst_end;

  // Scan offsets from farthest to nearest so the requester closest to ptr wins.
  always_comb begin
    winner = ptr;
    idx    = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) winner = idx;
    end
  end

  always_comb begin
    mux_data = a;
    case (sel)
      2'd0: mux_data = a;
      2'd1: mux_data = b;
      2'd2: mux_data = c;
      2'd3: mux_data = d;
    endcase
  end

  assign busy      = (state == GRANT);
  assign out_valid = busy & req[sel];
  assign y         = out_valid ? mux_data : '0;
  assign burst_end = !req[sel] || (out_ready && (beat_cnt == LAST_BEAT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= 2'd0;
      gnt      <= 4'b0000;
      ptr      <= 2'd0;
      beat_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state    <= GRANT;
            sel      <= winner;
            gnt      <= 4'b0001 << winner;
            beat_cnt <= 4'd0;
          end
        end
        GRANT: begin
          // sel is left alone at burst end; ptr advances past the finished owner.
          if (burst_end) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            ptr   <= sel + 2'd1;
          end else if (out_ready) begin
            beat_cnt <= beat_cnt + 4'd1;
          end
        end
      endcase
    end
  end

endmodule
